// File: rtl/sccb_pkg.sv
// Shared types and defaults for the SCCB master: FSM encoding, bit-quarter indices,
// default divider and device ID.
package sccb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WBYTE,
    S_RBYTE,
    S_STOP,
    S_GAP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int         DEF_DATA_W  = 8;
  localparam int         DEF_CLK_DIV = 500;
  localparam logic [7:0] DEF_DEV_ID  = 8'h42;

endpackage

// File: rtl/sccb_bit_timer.sv
// Bit-period divider: splits each SCCB bit into four equal quarters and flags the
// end of every quarter and of the whole bit. Held cleared while run=0.
import sccb_pkg::*;

module sccb_bit_timer #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic [1:0] qtr,
  output logic       q_tick,
  output logic       bit_end
);

  localparam int QLEN = CLK_DIV / 4;
  localparam int QW   = (QLEN > 1) ? $clog2(QLEN) : 1;

  logic [QW-1:0] qcnt;

  assign q_tick  = (qcnt == QW'(QLEN - 1));
  assign bit_end = q_tick && (qtr == Q3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt <= '0;
      qtr  <= Q0;
    end else if (!run) begin
      qcnt <= '0;
      qtr  <= Q0;
    end else if (q_tick) begin
      qcnt <= '0;
      qtr  <= qtr + 2'd1;
    end else begin
      qcnt <= qcnt + QW'(1);
    end
  end

endmodule

// File: rtl/sccb_master.sv
// SCCB master for the OV7670: 3-phase register writes, 2+2-phase register reads.
// Optional slave-ACK checking with abort on NACK is enabled by defining SCCB_ACK_CHK_EN.
import sccb_pkg::*;

module sccb_master #(
  parameter int                DATA_W  = DEF_DATA_W,
  parameter int                CLK_DIV = DEF_CLK_DIV,
  parameter logic [DATA_W-1:0] DEV_ID  = DATA_W'(DEF_DEV_ID)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdy,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_vld,
  output logic              ack_err,
  output logic              sio_c,
  output logic              sio_d_out,
  output logic              sio_d_oe,
  input  logic              sio_d_in
);

  localparam int                BW       = $clog2(DATA_W + 1);
  localparam logic [BW-1:0]     LAST_BIT = BW'(DATA_W);
  localparam logic [DATA_W-1:0] MSB      = DATA_W'(1) << (DATA_W - 1);

  state_t            state, state_nxt;
  logic              cmd_read, phase, abort;
  logic [1:0]        byte_idx;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] addr_q, wdata_q, rx_sh, tx_byte;
  logic              tx_bit;
  logic [1:0]        qtr;
  logic              q_tick, bit_end, sample, last_bit, last_wbyte, final_gap, accept;

  sccb_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state != S_IDLE),
    .qtr     (qtr),
    .q_tick  (q_tick),
    .bit_end (bit_end)
  );

  assign sample     = q_tick && (qtr == Q2);
  assign last_bit   = bit_end && (bit_cnt == LAST_BIT);
  assign last_wbyte = cmd_read ? (phase || byte_idx == 2'd1) : (byte_idx == 2'd2);
  // The last GAP clock doubles as the accept slot so commands can run back to back.
  assign final_gap  = (state == S_GAP) && bit_end && (!cmd_read || phase || abort);
  assign rdy        = (state == S_IDLE) || final_gap;
  assign accept     = rdy && (wr_en || rd_en);

  always_comb begin
    tx_byte = wdata_q;
    case (byte_idx)
      2'd0:    tx_byte = phase ? {DEV_ID[DATA_W-1:1], 1'b1} : DEV_ID;
      2'd1:    tx_byte = addr_q;
      default: tx_byte = wdata_q;
    endcase
  end

  assign tx_bit = |(tx_byte & (MSB >> bit_cnt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sio_c     = 1'b1;
    sio_d_out = 1'b1;
    sio_d_oe  = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_START;
      S_START: begin
        sio_c     = (qtr != Q3);
        sio_d_oe  = 1'b1;
        sio_d_out = (qtr == Q0) || (qtr == Q1);
        if (bit_end) state_nxt = S_WBYTE;
      end
      S_WBYTE: begin
        sio_c = (qtr == Q1) || (qtr == Q2);
        if (bit_cnt != LAST_BIT) begin
          sio_d_oe  = 1'b1;
          sio_d_out = tx_bit;
        end
        if (last_bit) begin
          if (abort || (last_wbyte && !(cmd_read && phase))) state_nxt = S_STOP;
          else if (last_wbyte)                               state_nxt = S_RBYTE;
          else                                               state_nxt = S_WBYTE;
        end
      end
      S_RBYTE: begin
        sio_c = (qtr == Q1) || (qtr == Q2);
        // Master answers every read byte with NA (SDA high, driven).
        if (bit_cnt == LAST_BIT) sio_d_oe = 1'b1;
        if (last_bit) state_nxt = S_STOP;
      end
      S_STOP: begin
        sio_c     = (qtr != Q0);
        sio_d_oe  = 1'b1;
        sio_d_out = (qtr == Q2) || (qtr == Q3);
        if (bit_end) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (bit_end) state_nxt = final_gap ? (accept ? S_START : S_IDLE) : S_START;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_read  <= 1'b0;
      phase     <= 1'b0;
      byte_idx  <= '0;
      bit_cnt   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rx_sh     <= '0;
      rdata     <= '0;
      rdata_vld <= 1'b0;
    end else begin
      rdata_vld <= 1'b0;
      if (accept) begin
        cmd_read <= rd_en && !wr_en;
        addr_q   <= addr;
        wdata_q  <= wdata;
        phase    <= 1'b0;
        byte_idx <= '0;
        bit_cnt  <= '0;
      end else begin
        if ((state == S_WBYTE || state == S_RBYTE) && bit_end) begin
          bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
          if (state == S_WBYTE && bit_cnt == LAST_BIT) byte_idx <= byte_idx + 2'd1;
        end
        if (state == S_RBYTE && sample && bit_cnt != LAST_BIT)
          rx_sh <= {rx_sh[DATA_W-2:0], sio_d_in};
        if (state == S_RBYTE && last_bit) begin
          rdata     <= rx_sh;
          rdata_vld <= 1'b1;
        end
        if (state == S_GAP && bit_end && !final_gap) begin
          phase    <= 1'b1;
          byte_idx <= '0;
        end
      end
    end
  end

`ifdef SCCB_ACK_CHK_EN
  logic abort_q, ack_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_q   <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      ack_err_q <= 1'b0;
      if (accept) begin
        abort_q <= 1'b0;
      end else if (state == S_WBYTE && sample && bit_cnt == LAST_BIT && sio_d_in) begin
        abort_q   <= 1'b1;
        ack_err_q <= 1'b1;
      end
    end
  end

  assign abort   = abort_q;
  assign ack_err = ack_err_q;
`else
  assign abort   = 1'b0;
  assign ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master (CLK_DIV=8) with a behavioural SCCB slave on a pulled-up SDA.
`timescale 1ns/1ps

module tb_sccb_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en;
  logic [7:0] addr, wdata;
  logic       rdy;
  logic [7:0] rdata;
  logic       rdata_vld, ack_err;
  logic       sio_c, sio_d_out, sio_d_oe, sda;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  int         starts = 0, stops = 0, vld_cnt = 0, ack_cnt = 0;
  logic [7:0] slave_data = 8'h00;
  logic       nack_id = 1'b0;
  logic       sl_low = 1'b0;

  always #5 clk = ~clk;

  assign sda = (sio_d_oe ? sio_d_out : 1'b1) & ~sl_low;

  sccb_master #(.DATA_W(8), .CLK_DIV(8), .DEV_ID(8'h42)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .wdata     (wdata),
    .rdy       (rdy),
    .rdata     (rdata),
    .rdata_vld (rdata_vld),
    .ack_err   (ack_err),
    .sio_c     (sio_c),
    .sio_d_out (sio_d_out),
    .sio_d_oe  (sio_d_oe),
    .sio_d_in  (sda)
  );

  // Slave: logs received bytes, ACKs (unless told to NACK the ID), answers a read ID with slave_data.
  initial begin
    logic       p_scl, p_sda, tx_mode, tx_next, skip;
    logic [7:0] rx, tx_sh;
    int         bitn, fb;
    p_scl = 1'b1; p_sda = 1'b1; tx_mode = 1'b0; tx_next = 1'b0; skip = 1'b0;
    rx = '0; tx_sh = '0; bitn = 0; fb = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sl_low = 1'b0; bitn = 0; tx_mode = 1'b0; tx_next = 1'b0; skip = 1'b0;
      end else if (sio_c && p_scl && p_sda && !sda) begin
        starts++;
        bitn = 0; fb = 0; tx_mode = 1'b0; tx_next = 1'b0; skip = 1'b1; sl_low = 1'b0;
      end else if (sio_c && p_scl && !p_sda && sda) begin
        stops++;
      end else if (sio_c && !p_scl) begin
        if (!tx_mode && bitn < 8) rx = {rx[6:0], sda};
      end else if (!sio_c && p_scl) begin
        if (skip) begin
          skip = 1'b0;
        end else if (tx_mode) begin
          if (bitn < 8) begin
            bitn++;
            tx_sh  = tx_sh << 1;
            sl_low = (bitn < 8) ? ~tx_sh[7] : 1'b0;
          end else begin
            bitn = 0; tx_mode = 1'b0;
          end
        end else if (bitn < 8) begin
          bitn++;
          if (bitn == 8) begin
            got.push_back(rx);
            tx_next = (fb == 0) && rx[0];
            sl_low  = !(nack_id && fb == 0);
            fb++;
          end
        end else begin
          bitn = 0; sl_low = 1'b0;
          if (tx_next) begin
            tx_mode = 1'b1; tx_next = 1'b0;
            tx_sh   = slave_data;
            sl_low  = ~tx_sh[7];
          end
        end
      end
      p_scl = sio_c;
      p_sda = sda;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rdata_vld) vld_cnt++;
    if (ack_err)   ack_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] getb(input int i);
    return (i < got.size()) ? got[i] : 8'hxx;
  endfunction

  // Called at a negedge with rdy=1; returns clocks from accept until rdy is seen again.
  task automatic run_cmd(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d,
                         output int cyc);
    wr_en = w; rd_en = r; addr = a; wdata = d; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      wr_en = 1'b0; rd_en = 1'b0;
    end while (!rdy && cyc < 1000);
  endtask

  typedef struct {
    logic       rd;
    logic [7:0] a, d, sdata;
    logic [7:0] b0, b1, b2;
    int         cyc;
    logic [7:0] exp_rdata;
    int         exp_vld;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   cyc, c1;

    vecs[0] = '{1'b0, 8'h12, 8'h80, 8'h00, 8'h42, 8'h12, 8'h80, 240, 8'h00, 0};
    vecs[1] = '{1'b1, 8'h0A, 8'hEE, 8'h76, 8'h42, 8'h0A, 8'h43, 336, 8'h76, 1};
    vecs[2] = '{1'b0, 8'h3D, 8'h03, 8'h00, 8'h42, 8'h3D, 8'h03, 240, 8'h76, 0};
    vecs[3] = '{1'b1, 8'h55, 8'h00, 8'hA5, 8'h42, 8'h55, 8'h43, 336, 8'hA5, 1};

    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_rdy", rdy, 1);
    chk("reset_sio_c", sio_c, 1);
    chk("reset_sio_d_out", sio_d_out, 1);
    chk("reset_sio_d_oe", sio_d_oe, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_rdata_vld", rdata_vld, 0);
    chk("reset_ack_err", ack_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      got.delete(); starts = 0; stops = 0; vld_cnt = 0; ack_cnt = 0;
      slave_data = vecs[i].sdata;
      run_cmd(!vecs[i].rd, vecs[i].rd, vecs[i].a, vecs[i].d, cyc);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_rdy_cycles", i), cyc, vecs[i].cyc);
      chk($sformatf("vec%0d_nbytes", i), got.size(), 3);
      chk($sformatf("vec%0d_byte0", i), getb(0), vecs[i].b0);
      chk($sformatf("vec%0d_byte1", i), getb(1), vecs[i].b1);
      chk($sformatf("vec%0d_byte2", i), getb(2), vecs[i].b2);
      chk($sformatf("vec%0d_starts", i), starts, vecs[i].rd ? 2 : 1);
      chk($sformatf("vec%0d_stops", i), stops, vecs[i].rd ? 2 : 1);
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_vld_pulses", i), vld_cnt, vecs[i].exp_vld);
      chk($sformatf("vec%0d_ack_err", i), ack_cnt, 0);
    end

    // write wins over read when both are requested
    got.delete(); vld_cnt = 0; starts = 0;
    run_cmd(1'b1, 1'b1, 8'h21, 8'h5A, cyc);
    repeat (2) @(negedge clk);
    chk("prio_cycles", cyc, 240);
    chk("prio_nbytes", got.size(), 3);
    chk("prio_byte0", getb(0), 8'h42);
    chk("prio_byte2", getb(2), 8'h5A);
    chk("prio_no_vld", vld_cnt, 0);

    // requests while busy are ignored
    got.delete(); starts = 0;
    wr_en = 1'b1; addr = 8'h30; wdata = 8'h31; cyc = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); cyc++; wr_en = 1'b0;
    end
    wr_en = 1'b1; rd_en = 1'b1; addr = 8'hFF; wdata = 8'hFF;
    @(negedge clk); cyc++; wr_en = 1'b0; rd_en = 1'b0;
    while (!rdy && cyc < 1000) begin
      @(negedge clk); cyc++;
    end
    repeat (300) @(negedge clk);
    chk("busy_cycles", cyc, 240);
    chk("busy_starts", starts, 1);
    chk("busy_nbytes", got.size(), 3);
    chk("busy_byte1", getb(1), 8'h30);

    // back-to-back writes: second accepted on the first rdy clock
    got.delete(); starts = 0;
    run_cmd(1'b1, 1'b0, 8'h12, 8'h80, c1);
    run_cmd(1'b1, 1'b0, 8'h3D, 8'h03, cyc);
    repeat (2) @(negedge clk);
    chk("b2b_first_cycles", c1, 240);
    chk("b2b_second_cycles", cyc, 240);
    chk("b2b_starts", starts, 2);
    chk("b2b_nbytes", got.size(), 6);
    chk("b2b_byte2", getb(2), 8'h80);
    chk("b2b_byte4", getb(4), 8'h3D);
    chk("b2b_byte5", getb(5), 8'h03);

    // reset in the middle of the address byte
    wr_en = 1'b1; addr = 8'h77; wdata = 8'h11;
    @(negedge clk); wr_en = 1'b0;
    repeat (108) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_sio_c", sio_c, 1);
    chk("midrst_sio_d_oe", sio_d_oe, 0);
    chk("midrst_rdy", rdy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got.delete(); starts = 0;
    run_cmd(1'b1, 1'b0, 8'h3D, 8'h03, cyc);
    repeat (2) @(negedge clk);
    chk("postrst_cycles", cyc, 240);
    chk("postrst_nbytes", got.size(), 3);
    chk("postrst_byte1", getb(1), 8'h3D);
    chk("postrst_byte2", getb(2), 8'h03);

`ifdef SCCB_ACK_CHK_EN
    // slave NACKs the ID byte: abort to STOP/GAP, no further bytes
    got.delete(); starts = 0; stops = 0; ack_cnt = 0; nack_id = 1'b1;
    run_cmd(1'b1, 1'b0, 8'h12, 8'h80, cyc);
    repeat (2) @(negedge clk);
    nack_id = 1'b0;
    chk("nack_ack_err", ack_cnt, 1);
    chk("nack_nbytes", got.size(), 1);
    chk("nack_stops", stops, 1);
    chk("nack_cycles", cyc, 96);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
